// File: rtl/math_pkg.sv
// math_pkg: elaboration-time math helpers shared across the codebase
package math_pkg;
  function automatic int log2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over req, searching from last_grant+1
module rr_arbiter
  import math_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [log2(N)-1:0]   index
);
  localparam int W = log2(N);
  logic [W-1:0] last_grant;
  logic found;
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[W'((int'(last_grant) + i) % N)]) begin
        found = 1'b1;
        index = W'((int'(last_grant) + i) % N);
      end
    end
    grant = found ? N'(1) << index : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) last_grant <= W'(N - 1);
    else if (advance && found) last_grant <= index;
endmodule

// File: rtl/stream_merger.sv
// stream_merger: N_CHS valid/ready streams merged and channel-tagged; STREAM_MERGER_CNT_EN adds o_word_cnt
module stream_merger
  import math_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_CHS      = 8,
  localparam int CH_W       = log2(N_CHS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_WIDTH*N_CHS-1:0] i_data,
  input  logic [N_CHS-1:0]            i_valid,
  output logic [N_CHS-1:0]            o_ready,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [CH_W-1:0]             o_ch_id,
  output logic                        o_valid,
  input  logic                        i_ready
`ifdef STREAM_MERGER_CNT_EN
  ,
  output logic [31:0]                 o_word_cnt
`endif
);
  logic [DATA_WIDTH-1:0] hold_data [N_CHS];
  logic [N_CHS-1:0] hold_full, grant, drain, take;
  logic [CH_W-1:0] g_idx;
  logic load;
  assign load = |hold_full & (~o_valid | i_ready);
  assign drain = grant & {N_CHS{load}};
  // i_ready feeds o_ready combinationally so a draining hold can refill in the same cycle
  assign o_ready = ~hold_full | drain;
  assign take = i_valid & o_ready;
  rr_arbiter #(.N(N_CHS)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     (hold_full),
    .advance (load),
    .grant   (grant),
    .index   (g_idx)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      hold_full <= '0;
      for (int c = 0; c < N_CHS; c++) hold_data[c] <= '0;
    end else begin
      hold_full <= take | (hold_full & ~drain);
      for (int c = 0; c < N_CHS; c++)
        if (take[c]) hold_data[c] <= i_data[DATA_WIDTH*c +: DATA_WIDTH];
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch_id <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= hold_data[g_idx];
      o_ch_id <= g_idx;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
`ifdef STREAM_MERGER_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_word_cnt <= '0;
    else if (o_valid && i_ready) o_word_cnt <= o_word_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_stream_merger.sv
// tb_stream_merger: randomized and directed checks of stream_merger against a behavioural model
module tb_stream_merger;
  localparam int DW = 32;
  localparam int N  = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW*N-1:0] i_data = '0;
  logic [N-1:0] i_valid = '0;
  logic [N-1:0] o_ready;
  logic [DW-1:0] o_data;
  logic [2:0] o_ch_id;
  logic o_valid;
  logic i_ready = 1'b0;
`ifdef STREAM_MERGER_CNT_EN
  logic [31:0] o_word_cnt;
`endif
  stream_merger #(.DATA_WIDTH(DW), .N_CHS(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_ch_id (o_ch_id),
    .o_valid (o_valid),
    .i_ready (i_ready)
`ifdef STREAM_MERGER_CNT_EN
    ,
    .o_word_cnt (o_word_cnt)
`endif
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  bit m_full [N];
  logic [DW-1:0] m_hold [N];
  bit m_ov;
  logic [DW-1:0] m_od;
  int m_oc;
  int m_last;
  longint m_cnt;
  logic [N-1:0] last_rdy;
  logic [DW-1:0] log_d [$];
  int log_c [$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_full[c] = 0;
      m_hold[c] = '0;
    end
    m_ov = 0;
    m_od = '0;
    m_oc = 0;
    m_last = N - 1;
    m_cnt = 0;
  endtask
  // one cycle: drive, compare against the model, advance the model, cross the edge
  task automatic step(input logic [N-1:0] v, input logic [DW*N-1:0] d, input logic r);
    bit any_full, load;
    int pick;
    logic [N-1:0] exp_rdy;
    i_valid = v;
    i_data = d;
    i_ready = r;
    #1;
    chk("o_valid", o_valid, m_ov);
    if (m_ov) begin
      chk("o_data", o_data, m_od);
      chk("o_ch_id", o_ch_id, m_oc);
    end
`ifdef STREAM_MERGER_CNT_EN
    chk("o_word_cnt", o_word_cnt, m_cnt[31:0]);
`endif
    any_full = 0;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      int c = (m_last + k) % N;
      if (m_full[c]) begin
        any_full = 1;
        if (pick < 0) pick = c;
      end
    end
    load = any_full && (!m_ov || r);
    for (int c = 0; c < N; c++) exp_rdy[c] = !m_full[c] || (load && c == pick);
    chk("o_ready", o_ready, exp_rdy);
    last_rdy = exp_rdy;
    if (m_ov && r) begin
      log_d.push_back(m_od);
      log_c.push_back(m_oc);
      m_cnt++;
    end
    if (load) begin
      m_ov = 1;
      m_od = m_hold[pick];
      m_oc = pick;
      m_last = pick;
      m_full[pick] = 0;
    end else if (r) m_ov = 0;
    for (int c = 0; c < N; c++)
      if (v[c] && exp_rdy[c]) begin
        m_hold[c] = d[DW*c +: DW];
        m_full[c] = 1;
      end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_o_valid_async", o_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      i_valid = 8'hFF;
      i_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      i_ready = 1'b1;
      @(negedge clk);
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_o_data", o_data, 32'h0);
      chk("rst_o_ch_id", o_ch_id, 3'd0);
      chk("rst_o_ready", o_ready, 8'hFF);
    end
    rst_n = 1'b1;
  endtask
  task automatic clear_log();
    log_d.delete();
    log_c.delete();
  endtask
  initial begin
    logic [DW*N-1:0] d;
    int k;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1);
    chk("post_rst_empty", log_d.size(), 0);
    // single channel, back-to-back
    clear_log();
    d = '0; d[DW*3 +: DW] = 32'h11;
    step(8'h08, d, 1'b1);
    chk("lat_edge_k", o_valid, 1'b0);
    d[DW*3 +: DW] = 32'h22;
    step(8'h08, d, 1'b1);
    chk("lat_edge_k1", o_valid, 1'b1);
    chk("lat_data", o_data, 32'h11);
    d[DW*3 +: DW] = 32'h33;
    step(8'h08, d, 1'b1);
    for (int i = 0; i < 4; i++) step('0, '0, 1'b1);
    chk("single_cnt", log_d.size(), 3);
    for (int i = 0; i < 3 && i < log_d.size(); i++) begin
      chk("single_data", log_d[i], 32'h11 * (i + 1));
      chk("single_ch", log_c[i], 3);
    end
    // fairness
    do_reset();
    clear_log();
    d = '0;
    for (int c = 0; c < N; c++) d[DW*c +: DW] = c;
    for (int i = 0; i < 26; i++) step(8'hFF, d, 1'b1);
    for (int i = 0; i < 12; i++) step('0, '0, 1'b1);
    chk("fair_min", log_d.size() >= 24, 1);
    for (int i = 0; i < log_d.size(); i++) begin
      chk("fair_ch", log_c[i], i % N);
      chk("fair_data", log_d[i], i % N);
    end
    // backpressure
    clear_log();
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < N; c++) d[DW*c +: DW] = (c << 8) | i;
      step(8'hFF, d, 1'b0);
    end
    chk("bp_ready_low", o_ready, 8'h00);
    chk("bp_valid", o_valid, 1'b1);
    for (int i = 0; i < 15; i++) step('0, '0, 1'b1);
    chk("bp_release_cnt", log_d.size(), 9);
    // same-channel drain/capture with toggling ready
    clear_log();
    k = 0;
    for (int i = 0; i < 40; i++) begin
      d = '0;
      d[DW*5 +: DW] = 32'hA0 + k;
      step(k < 8 ? 8'h20 : 8'h00, d, i[0] == 1'b0);
      if (k < 8 && last_rdy[5]) k++;
    end
    chk("same_cnt", log_d.size(), 8);
    for (int i = 0; i < 8 && i < log_d.size(); i++) begin
      chk("same_data", log_d[i], 32'hA0 + i);
      chk("same_ch", log_c[i], 5);
    end
    // randomized traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        do_reset();
      end
      for (int c = 0; c < N; c++) d[DW*c +: DW] = $urandom;
      step(N'($urandom), d, $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_merger.md
# stream_merger

Merges N_CHS independent valid/ready channel streams into a single output stream, tagging each word with its source channel. It is the collecting counterpart of the input-side crossbar: per-channel decoder results are funnelled back onto one bus for the output interface. Each channel has a one-word holding register, a round-robin arbiter picks among occupied channels, and a registered output stage honours downstream backpressure.

## Interface
- DATA_WIDTH, 32, width of one data word
- N_CHS, 8, number of input channels; must be ≥ 2
- CH_W, log2(N_CHS), channel-index width; derived localparam, not overridable
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low; one clock, reset asynchronous and active-low
- i_data  in  DATA_WIDTH*N_CHS  channel words; channel ch at [DATA_WIDTH*(ch+1)-1 -: DATA_WIDTH]
- i_valid  in  N_CHS  per-channel word valid
- o_ready  out  N_CHS  per-channel accept; transfer on ch when i_valid[ch] & o_ready[ch] at clock edge
- o_data  out  DATA_WIDTH  merged word
- o_ch_id  out  CH_W  source channel of o_data
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accept; output transfer when o_valid & i_ready at clock edge

## Operation
- Holding register per channel: hold_data[ch], hold_full[ch]. Captures i_data slice on input transfer; sets hold_full.
- o_ready[ch] = ~hold_full[ch] | drain[ch], where drain[ch] = grant[ch] & load. Combinational path i_ready -> o_ready is intentional (full per-channel throughput).
- load = any(hold_full) & (~o_valid | i_ready).
- Arbiter: round-robin over hold_full. Search starts at last_grant+1, wraps at N_CHS-1 -> 0. grant is one-hot, zero when no hold_full. last_grant updates to granted index only on load.
- Output register: on load, o_data <= hold_data[g], o_ch_id <= g, o_valid <= 1. On output transfer without load, o_valid <= 0. o_data/o_ch_id hold value while o_valid & ~i_ready.
- Simultaneous capture and drain on same channel: hold_data takes new word, hold_full stays 1.
- Data never dropped, reordered within a channel, or duplicated.

## Timing
- Reset values: o_valid 0, o_data 0, o_ch_id 0, hold_full all 0, last_grant N_CHS-1 (channel 0 wins first). o_ready all 1 while out of reset with empty holds.
- Latency: input transfer at edge k -> o_valid high after edge k+1 if output free (2-edge path, 1 cycle visible delay).
- Throughput: one output word per cycle aggregate; single continuously-valid channel sustains 1 word/cycle.
- Reset assertion mid-operation: all holding and output contents discarded immediately; no partial words emitted after deassertion.
- Downstream stall: o_valid, o_data, o_ch_id stable until i_ready; holds fill, then o_ready drops per channel.

## Configuration
- STREAM_MERGER_CNT_EN defined: adds output port o_word_cnt (out, 32) counting output transfers; reset 0, +1 per o_valid & i_ready, wraps 2^32-1 -> 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- log2 comes from math_pkg (imported); no new package types required. Channel-index width constants derived locally.
- One sub-module: rr_arbiter (parameter N; inputs req[N], advance, outputs one-hot grant, binary index; owns last_grant register, i_clk/i_rst_n).

## Test plan
- Reset: hold i_rst_n low 3 cycles with i_valid=8'hFF -> o_valid=0, o_data=0, o_ch_id=0, nothing emitted after release until new captures.
- Single channel: ch3 sends 0x11,0x22,0x33 back-to-back, i_ready=1 -> outputs same order, o_ch_id=3, one word per cycle, first o_valid one cycle after first capture.
- Fairness: all 8 channels continuously valid, word = ch index -> o_ch_id sequence 0,1,…,7,0,1… with no channel skipped.
- Backpressure: i_ready=0 for 10 cycles with all channels sending -> o_data/o_ch_id stable, o_ready drops to 0 on all channels; on release all 8 held words plus output word emerge, none lost.
- Same-channel drain/capture: ch5 streams 0xA0..0xA7 with i_ready toggling 1/0 -> exactly 8 outputs in order, o_ch_id=5.
- With STREAM_MERGER_CNT_EN: 100 output transfers -> o_word_cnt=100; preload near wrap via forced count 32'hFFFF_FFFF, one transfer -> 0.
